round_banner_ctrl: RTL and testbench

Sequencer for the full-screen round-number banner sprites (Round1/Round2/Round3 ROM+palette pipelines). On a round-start request it selects the banner sprite, drives a per-frame fade-in / hold / fade-out intensity envelope synchronised to the VGA frame, and pulses `done` when the banner has cleared. It sits between game-state logic and the banner sprite pixel path. The top level applies `overlay_en`, `sprite_sel` and `intensity` to mux and scale the palette RGB.

---
 rtl/round_banner_pkg.sv | 18 +
 rtl/frame_tick_gen.sv | 26 ++
 rtl/round_banner_ctrl.sv | 165 ++++++++++++++++
 tb/tb_round_banner_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_banner_pkg.sv
// == round_banner_pkg : shared state encoding and constants for the round banner sequencer (rev 1.0) ==
`default_nettype none
package round_banner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_IN  = 2'd1,
    ST_HOLD     = 2'd2,
    ST_FADE_OUT = 2'd3
  } state_e;

  localparam logic [3:0] INTENSITY_MAX  = 4'hF;
  localparam logic [1:0] ROUND_NONE     = 2'd0;
  localparam logic [9:0] FRAME_ORIGIN_X = 10'd0;
  localparam logic [9:0] FRAME_ORIGIN_Y = 10'd0;

endpackage
`default_nettype wire

// File: rtl/frame_tick_gen.sv
// == frame_tick_gen : registered one-cycle pulse after the raster origin is sampled (rev 1.0) ==
`default_nettype none
module frame_tick_gen
  import round_banner_pkg::*;
(
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       frame_tick
);

  logic tick_q;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= (DrawX == FRAME_ORIGIN_X) && (DrawY == FRAME_ORIGIN_Y);
    end
  end

  assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/round_banner_ctrl.sv
// == round_banner_ctrl : round banner sprite select + per-frame intensity envelope (rev 1.0) ==
// == Define ROUND_BANNER_FADE_EN to build the fade-in/fade-out phases; otherwise start jumps to HOLD. ==
`default_nettype none
module round_banner_ctrl
  import round_banner_pkg::*;
#(
  parameter int HOLD_FRAMES = 120,
  parameter int FADE_STEP   = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       round_start,
  input  logic [1:0] round_num,
  input  logic       abort,
  output logic       busy,
  output logic       overlay_en,
  output logic [1:0] sprite_sel,
  output logic [3:0] intensity,
  output logic       done
);

  if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_hold_range_chk
    $error("HOLD_FRAMES must be 1..255");
  end
  if (FADE_STEP < 1 || FADE_STEP > 15) begin : g_step_range_chk
    $error("FADE_STEP must be 1..15");
  end

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_FRAMES);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] int_q, int_d;
  logic [7:0] hold_q, hold_d;
  logic       done_q, done_d;
  logic       frame_tick;
  logic       hold_exit;
`ifdef ROUND_BANNER_FADE_EN
  localparam logic [3:0] STEP_LIM = 4'(FADE_STEP);
  logic [3:0] step_q, step_d;
`endif

  frame_tick_gen u_tick (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .frame_tick (frame_tick)
  );

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= ROUND_NONE;
      int_q   <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
`ifdef ROUND_BANNER_FADE_EN
      step_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      int_q   <= int_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
`ifdef ROUND_BANNER_FADE_EN
      step_q  <= step_d;
`endif
    end
  end

  // abort overrides a coincident tick; expiry compares before increment so the count never wraps
  assign hold_exit = abort || (frame_tick && (hold_q >= HOLD_LIM - 8'd1));
  assign done_d    = (state_q != ST_IDLE) && (state_d == ST_IDLE);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    int_d   = int_q;
    hold_d  = hold_q;
`ifdef ROUND_BANNER_FADE_EN
    step_d  = step_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (round_start && (round_num != ROUND_NONE) && !abort) begin
          sel_d  = round_num;
          hold_d = '0;
`ifdef ROUND_BANNER_FADE_EN
          state_d = ST_FADE_IN;
          int_d   = '0;
          step_d  = '0;
`else
          state_d = ST_HOLD;
          int_d   = INTENSITY_MAX;
`endif
        end
      end
      ST_HOLD: begin
        if (hold_exit) begin
`ifdef ROUND_BANNER_FADE_EN
          state_d = ST_FADE_OUT;
          step_d  = '0;
`else
          state_d = ST_IDLE;
          sel_d   = ROUND_NONE;
          int_d   = '0;
`endif
        end else if (frame_tick) begin
          hold_d = hold_q + 8'd1;
        end
      end
`ifdef ROUND_BANNER_FADE_EN
      ST_FADE_IN: begin
        if (abort) begin
          state_d = ST_FADE_OUT;
          step_d  = '0;
        end else if (frame_tick) begin
          if (step_q >= STEP_LIM - 4'd1) begin
            step_d = '0;
            int_d  = int_q + 4'd1;
            if (int_q == INTENSITY_MAX - 4'd1) begin
              state_d = ST_HOLD;
              hold_d  = '0;
            end
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
      ST_FADE_OUT: begin
        if (frame_tick) begin
          if (int_q == '0) begin
            state_d = ST_IDLE;
            sel_d   = ROUND_NONE;
          end else if (step_q >= STEP_LIM - 4'd1) begin
            step_d = '0;
            int_d  = int_q - 4'd1;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        sel_d   = ROUND_NONE;
        int_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    overlay_en = busy;
    sprite_sel = sel_q;
    intensity  = int_q;
    done       = done_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_round_banner_ctrl.sv
// == tb_round_banner_ctrl : randomized bench with a tick-count envelope model of the banner sequencer (rev 1.0) ==
`timescale 1ns/1ps
`default_nettype none
module tb_round_banner_ctrl;

  localparam int H  = 4;
  localparam int FS = 1;
`ifdef ROUND_BANNER_FADE_EN
  localparam bit FADE      = 1'b1;
  localparam int TOTAL     = 30 * FS + H + 1;
  localparam logic [3:0] START_INT = 4'd0;
`else
  localparam bit FADE      = 1'b0;
  localparam int TOTAL     = H;
  localparam logic [3:0] START_INT = 4'd15;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       round_start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] round_num = 2'd0;
  logic [9:0] DrawX = 10'd7;
  logic [9:0] DrawY = 10'd3;
  logic       busy, overlay_en, done;
  logic [1:0] sprite_sel;
  logic [3:0] intensity;
  logic [8:0] dut_out, exp_out;
  int         n_cmp = 0, n_fail = 0;

  // Model: banner described by ticks elapsed since start (or since abort) plus the intensity at abort.
  bit         m_act = 1'b0, m_ab = 1'b0, m_done = 1'b0, tick_pend = 1'b0, last_tick = 1'b0;
  int         m_e = 0, m_m = 0, m_ia = 0, fcnt = 0;
  logic [1:0] m_sel = 2'd0;

  always #5 clk = ~clk;
  assign dut_out = {busy, overlay_en, sprite_sel, intensity, done};

  round_banner_ctrl #(.HOLD_FRAMES(H), .FADE_STEP(FS)) dut (
    .vga_clk     (clk),
    .reset       (rst),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .round_start (round_start),
    .round_num   (round_num),
    .abort       (abort),
    .busy        (busy),
    .overlay_en  (overlay_en),
    .sprite_sel  (sprite_sel),
    .intensity   (intensity),
    .done        (done)
  );

  function automatic int cur_int();
    if (!m_act) return 0;
    if (!FADE) return 15;
    if (m_ab) return m_ia - m_m / FS;
    if (m_e < 15 * FS) return m_e / FS;
    if (m_e < 15 * FS + H) return 15;
    return 15 - (m_e - 15 * FS - H) / FS;
  endfunction

  function automatic bit finished();
    if (!FADE) return m_e == H;
    return m_ab ? (m_m == m_ia * FS + 1) : (m_e == 30 * FS + H + 1);
  endfunction

  function automatic bit in_fade_out();
    return FADE && (m_ab || m_e >= 15 * FS + H);
  endfunction

  // Advance one clock, update the model from the inputs the DUT just sampled, then drive the raster.
  task automatic cyc();
    @(posedge clk);
    #1;
    last_tick = tick_pend;
    tick_pend = !rst && DrawX == 10'd0 && DrawY == 10'd0;
    m_done = 1'b0;
    if (rst) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (round_start && round_num != 2'd0 && !abort) begin
        m_act = 1'b1; m_sel = round_num; m_e = 0; m_m = 0; m_ab = 1'b0;
      end
    end else if (abort && !in_fade_out()) begin
      if (FADE) begin
        m_ia = cur_int(); m_ab = 1'b1; m_m = 0;
      end else begin
        m_act = 1'b0; m_done = 1'b1;
      end
    end else if (last_tick) begin
      if (m_ab) m_m++; else m_e++;
      if (finished()) begin m_act = 1'b0; m_done = 1'b1; end
    end
    exp_out = {m_act, m_act, (m_act ? m_sel : 2'd0), 4'(cur_int()), m_done};
    fcnt = (fcnt == 9) ? 0 : fcnt + 1;
    if (fcnt == 0) begin
      DrawX = 10'd0; DrawY = 10'd0;
    end else begin
      case ($urandom_range(2))
        0: begin DrawX = 10'd0; DrawY = 10'($urandom_range(524, 1)); end
        1: begin DrawX = 10'($urandom_range(799, 1)); DrawY = 10'd0; end
        default: begin DrawX = 10'($urandom_range(799, 1)); DrawY = 10'($urandom_range(524, 1)); end
      endcase
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    n_cmp++;
    if (dut_out !== 9'd0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=%h", dut_out, 9'd0); end
    rst = 1'b0;
    repeat (12) begin
      cyc();
      n_cmp++;
      if (dut_out !== exp_out) begin n_fail++; $display("FAIL reset_idle got=%h exp=%h", dut_out, exp_out); end
    end
  endtask

  task automatic test_full_banner();
    int ticks = 0, dones = 0, maxi = 0, n = 0;
    round_start = 1'b1; round_num = 2'd2;
    cyc();
    round_start = 1'b0;
    n_cmp++;
    if ({busy, overlay_en, sprite_sel, intensity} !== {2'b11, 2'd2, START_INT}) begin
      n_fail++; $display("FAIL start_accept got=%b%b sel=%0d int=%0d exp sel=2 int=%0d", busy, overlay_en, sprite_sel, intensity, START_INT);
    end
    while (done !== 1'b1 && n < 2000) begin
      cyc(); n++;
      ticks += int'(last_tick);
      if (int'(intensity) > maxi) maxi = int'(intensity);
      if (done === 1'b1) dones++;
      n_cmp++;
      if (dut_out !== exp_out) begin n_fail++; $display("FAIL full_banner cyc=%0d got=%h exp=%h", n, dut_out, exp_out); end
    end
    n_cmp++;
    if (n >= 2000) begin n_fail++; $display("FAIL full_banner_timeout waited=%0d cycles for done", n); end
    n_cmp++;
    if (ticks != TOTAL) begin n_fail++; $display("FAIL banner_length got=%0d ticks exp=%0d", ticks, TOTAL); end
    n_cmp++;
    if (maxi != 15) begin n_fail++; $display("FAIL peak_intensity got=%0d exp=15", maxi); end
    repeat (25) begin
      cyc();
      if (done === 1'b1) dones++;
      n_cmp++;
      if (dut_out !== exp_out) begin n_fail++; $display("FAIL after_done got=%h exp=%h", dut_out, exp_out); end
    end
    n_cmp++;
    if (dones != 1) begin n_fail++; $display("FAIL done_pulses got=%0d exp=1", dones); end
  endtask

  task automatic test_ignored();
    int n = 0;
    round_start = 1'b1; round_num = 2'd0;
    cyc();
    round_start = 1'b0;
    repeat (3) begin
      cyc();
      n_cmp++;
      if (dut_out !== 9'd0) begin n_fail++; $display("FAIL num0_ignored got=%h exp=%h", dut_out, 9'd0); end
    end
    round_start = 1'b1; round_num = 2'd1;
    cyc();
    round_num = 2'd3;
    repeat (2) cyc();
    round_start = 1'b0;
    n_cmp++;
    if (sprite_sel !== 2'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_restart sel=%0d busy=%b exp sel=1 busy=1", sprite_sel, busy);
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    while ((m_act || busy === 1'b1) && n < 1000) begin
      cyc(); n++;
      n_cmp++;
      if (dut_out !== exp_out) begin n_fail++; $display("FAIL ignored_drain got=%h exp=%h", dut_out, exp_out); end
    end
    cyc();
  endtask

  task automatic test_abort_hold();
    int n = 0, decs = 0, dones = 0;
    logic [3:0] prev;
    round_start = 1'b1; round_num = 2'd3;
    cyc();
    round_start = 1'b0;
    while (m_e < (FADE ? 15 * FS + 1 : 1) && n < 1000) begin
      cyc(); n++;
      n_cmp++;
      if (dut_out !== exp_out) begin n_fail++; $display("FAIL abort_lead got=%h exp=%h", dut_out, exp_out); end
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    n_cmp++;
    if (FADE ? ({busy, done, intensity} !== 6'b10_1111) : ({busy, done} !== 2'b01)) begin
      n_fail++; $display("FAIL abort_response busy=%b done=%b int=%0d exp busy=%b done=%b", busy, done, intensity, FADE, !FADE);
    end
    dones = int'(done);
    prev = intensity;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      cyc(); n++;
      if (intensity == prev - 4'd1) decs++;
      prev = intensity;
      if (done === 1'b1) dones++;
      n_cmp++;
      if (dut_out !== exp_out) begin n_fail++; $display("FAIL abort_fade got=%h exp=%h", dut_out, exp_out); end
    end
    n_cmp++;
    if (decs != (FADE ? 15 : 0) || dones != 1) begin
      n_fail++; $display("FAIL abort_steps decs=%0d dones=%0d exp decs=%0d dones=1", decs, dones, FADE ? 15 : 0);
    end
    cyc();
  endtask

  task automatic test_start_abort_same();
    round_start = 1'b1; round_num = 2'd1; abort = 1'b1;
    cyc();
    round_start = 1'b0; abort = 1'b0;
    n_cmp++;
    if (dut_out !== 9'd0) begin n_fail++; $display("FAIL start_with_abort got=%h exp=%h", dut_out, 9'd0); end
    cyc();
    n_cmp++;
    if (dut_out !== exp_out) begin n_fail++; $display("FAIL start_with_abort_next got=%h exp=%h", dut_out, exp_out); end
  endtask

  task automatic test_reset_mid_hold();
    int n = 0;
    round_start = 1'b1; round_num = 2'd2;
    cyc();
    round_start = 1'b0;
    while (m_e < (FADE ? 15 * FS + 2 : 2) && n < 1000) begin cyc(); n++; end
    n_cmp++;
    if (busy !== 1'b1 || intensity !== 4'd15) begin
      n_fail++; $display("FAIL pre_reset_hold busy=%b int=%0d exp busy=1 int=15", busy, intensity);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_cmp++;
    if (dut_out !== 9'd0) begin n_fail++; $display("FAIL reset_mid_hold got=%h exp=%h", dut_out, 9'd0); end
    repeat (15) begin
      cyc();
      n_cmp++;
      if (dut_out !== exp_out) begin n_fail++; $display("FAIL post_reset got=%h exp=%h", dut_out, exp_out); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      round_start = ($urandom_range(24) == 0);
      round_num   = 2'($urandom_range(3));
      abort       = ($urandom_range(89) == 0);
      rst         = ($urandom_range(1499) == 0);
      cyc();
      n_cmp++;
      if (dut_out !== exp_out) begin n_fail++; $display("FAIL random i=%0d got=%h exp=%h", i, dut_out, exp_out); end
    end
    round_start = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_banner();
    test_ignored();
    test_abort_hold();
    test_start_abort_same();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
